// File: rtl/data_mem_responder.sv
// Data-memory responder for the 5-stage RISC-V pipeline: word-organised RAM with a
// fixed access latency, byte/half/word lanes, load extension and a pipeline stall.
module data_mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  output logic [31:0] rdata,
  output logic        resp_valid,
  output logic        misaligned,
  output logic        mem_stall
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [3:0]          r_cnt;
  logic [ADDR_W+1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [1:0]          r_size;
  logic                r_unsigned;
  logic                r_write;
  logic                r_misal;
  logic [31:0]         r_rdata;
  logic [31:0]         r_mem [0:(1<<ADDR_W)-1];

  logic                w_req;
  logic                w_misal_in;
  logic                w_access;
  logic [ADDR_W-1:0]   w_idx;
  logic [31:0]         w_rd_word;
  logic [15:0]         w_lane;
  logic [31:0]         w_load_ext;
  logic [3:0]          w_be;
  logic [31:0]         w_wr_data;
  logic                w_unused;

  // Upper address bits are deliberately ignored so addresses alias modulo the RAM size.
  assign w_unused   = &{1'b0, addr[31:ADDR_W+2]};
  assign w_req      = mem_read | mem_write;
  assign w_misal_in = ((mem_size == 2'b01) & addr[0]) | (mem_size[1] & (|addr[1:0]));
  assign w_access   = (r_state == WAIT) && (r_cnt == 4'd0);
  assign w_idx      = r_addr[ADDR_W+1:2];
  assign rdata      = r_rdata;

  always_comb begin
    w_state_next = r_state;
    mem_stall    = 1'b0;
    resp_valid   = 1'b0;
    misaligned   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          mem_stall    = 1'b1;
          w_state_next = w_misal_in ? RESP : WAIT;
        end
      end
      WAIT: begin
        mem_stall = 1'b1;
        if (r_cnt == 4'd0) w_state_next = RESP;
      end
      RESP: begin
        resp_valid   = 1'b1;
        misaligned   = r_misal;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    if (reset) mem_stall = 1'b0;
  end

  // Half accesses are known even-aligned here, so one byte-granular shift serves both sizes.
  always_comb begin
    w_rd_word  = r_mem[w_idx];
    w_lane     = 16'(w_rd_word >> {r_addr[1:0], 3'b000});
    w_load_ext = w_rd_word;
    case (r_size)
      2'b00:   w_load_ext = {{24{~r_unsigned & w_lane[7]}}, w_lane[7:0]};
      2'b01:   w_load_ext = {{16{~r_unsigned & w_lane[15]}}, w_lane[15:0]};
      default: w_load_ext = w_rd_word;
    endcase
  end

  always_comb begin
    w_be      = 4'b1111;
    w_wr_data = r_wdata;
    case (r_size)
      2'b00: begin
        w_be      = 4'b0001 << r_addr[1:0];
        w_wr_data = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be      = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wr_data = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be      = 4'b1111;
        w_wr_data = r_wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= 4'd0;
      r_rdata    <= 32'd0;
      r_misal    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= 32'd0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_write    <= 1'b0;
    end else if (r_state == IDLE && w_req) begin
      r_addr     <= addr[ADDR_W+1:0];
      r_wdata    <= wdata;
      r_size     <= mem_size;
      r_unsigned <= mem_unsigned;
      r_write    <= mem_write;
      r_misal    <= w_misal_in;
      r_cnt      <= 4'(LATENCY - 1);
      if (w_misal_in) r_rdata <= 32'd0;
    end else if (r_state == WAIT) begin
      if (r_cnt != 4'd0) r_cnt   <= r_cnt - 4'd1;
      else               r_rdata <= r_write ? 32'd0 : w_load_ext;
    end
  end

  // RAM contents survive reset; only an in-flight store is cancelled.
  always_ff @(posedge clk) begin
    if (!reset && w_access && r_write) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][i*8 +: 8] <= w_wr_data[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: scoreboard of expected responses plus
// stall-length, alias, misalignment and mid-transaction reset checks.
module tb_data_mem_responder;

  localparam int ADDR_W  = 8;
  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] rdata;
  logic        resp_valid;
  logic        misaligned;
  logic        mem_stall;

  typedef struct packed {
    logic [31:0] rd;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  data_mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .addr         (addr),
    .wdata        (wdata),
    .mem_size     (mem_size),
    .mem_unsigned (mem_unsigned),
    .rdata        (rdata),
    .resp_valid   (resp_valid),
    .misaligned   (misaligned),
    .mem_stall    (mem_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, hold it while stalled, and check the response against the scoreboard.
  task automatic req(input string tag, input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] wd, input logic [1:0] sz, input logic uns,
                     input logic [31:0] exp_rd, input logic exp_mis);
    int   stalls;
    int   exp_stalls;
    logic got;
    exp_t e;
    @(negedge clk);
    mem_read     = rd;
    mem_write    = wr;
    addr         = a;
    wdata        = wd;
    mem_size     = sz;
    mem_unsigned = uns;
    sb.push_back('{rd: exp_rd, mis: exp_mis});
    exp_stalls = exp_mis ? 1 : LATENCY + 1;
    stalls = 0;
    got    = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      #1;
      if (resp_valid) begin
        got = 1'b1;
        chk({tag, "_stall_at_resp"}, 32'(mem_stall), 32'd0);
        if (sb.size() == 0) begin
          chk({tag, "_unexpected_resp"}, 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk({tag, "_rdata"}, rdata, e.rd);
          chk({tag, "_misaligned"}, 32'(misaligned), 32'(e.mis));
        end
      end else begin
        if (mem_stall) stalls++;
        @(negedge clk);
      end
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    chk({tag, "_timeout"}, 32'(got), 32'd1);
    chk({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_stalls));
    @(negedge clk);
    #1;
    chk({tag, "_pulse_end"}, 32'({resp_valid, mem_stall}), 32'd0);
    chk({tag, "_rdata_hold"}, rdata, exp_rd);
  endtask

  initial begin
    reset        = 1'b1;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    addr         = 32'd0;
    wdata        = 32'd0;
    mem_size     = 2'b10;
    mem_unsigned = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_misaligned", 32'(misaligned), 32'd0);
    chk("reset_stall", 32'(mem_stall), 32'd0);

    req("sw_10",  1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0000_0000, 1'b0);
    req("lw_10",  1'b1, 1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0);
    req("lb_13",  1'b1, 1'b0, 32'h13, 32'h0,        2'b00, 1'b0, 32'hFFFF_FFDE, 1'b0);
    req("lbu_13", 1'b1, 1'b0, 32'h13, 32'h0,        2'b00, 1'b1, 32'h0000_00DE, 1'b0);
    req("lh_12",  1'b1, 1'b0, 32'h12, 32'h0,        2'b01, 1'b0, 32'hFFFF_DEAD, 1'b0);
    req("lhu_10", 1'b1, 1'b0, 32'h10, 32'h0,        2'b01, 1'b1, 32'h0000_BEEF, 1'b0);
    req("lb_10",  1'b1, 1'b0, 32'h10, 32'h0,        2'b00, 1'b0, 32'hFFFF_FFEF, 1'b0);

    req("sb_11",  1'b0, 1'b1, 32'h11, 32'h12345677, 2'b00, 1'b0, 32'h0000_0000, 1'b0);
    req("lw_sb",  1'b1, 1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 32'hDEAD_77EF, 1'b0);
    req("lb_11",  1'b1, 1'b0, 32'h11, 32'h0,        2'b00, 1'b0, 32'h0000_0077, 1'b0);
    req("sh_12",  1'b0, 1'b1, 32'h12, 32'h0000A5A5, 2'b01, 1'b0, 32'h0000_0000, 1'b0);
    req("lw_sh",  1'b1, 1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 32'hA5A5_77EF, 1'b0);

    req("lw_mis", 1'b1, 1'b0, 32'h12, 32'h0,        2'b10, 1'b0, 32'h0000_0000, 1'b1);
    req("sh_mis", 1'b0, 1'b1, 32'h13, 32'h0000FFFF, 2'b01, 1'b0, 32'h0000_0000, 1'b1);
    req("lw11_mis", 1'b1, 1'b0, 32'h11, 32'h0,      2'b11, 1'b0, 32'h0000_0000, 1'b1);
    req("lw_nochg", 1'b1, 1'b0, 32'h10, 32'h0,      2'b10, 1'b0, 32'hA5A5_77EF, 1'b0);

    req("sw_20",  1'b0, 1'b1, 32'h20, 32'h11111111, 2'b10, 1'b0, 32'h0000_0000, 1'b0);
    req("lw_20a", 1'b1, 1'b0, 32'h20, 32'h0,        2'b10, 1'b0, 32'h1111_1111, 1'b0);
    @(negedge clk);
    mem_write = 1'b1;
    addr      = 32'h20;
    wdata     = 32'hCAFEF00D;
    mem_size  = 2'b10;
    #1;
    chk("abort_accept_stall", 32'(mem_stall), 32'd1);
    @(negedge clk);
    reset     = 1'b1;
    mem_write = 1'b0;
    #1;
    chk("abort_stall_in_reset", 32'(mem_stall), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_rdata", rdata, 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("abort_idle", 32'({resp_valid, mem_stall}), 32'd0);
      @(negedge clk);
      #1;
    end
    req("lw_20b", 1'b1, 1'b0, 32'h20, 32'h0,        2'b10, 1'b0, 32'h1111_1111, 1'b0);

    req("sw_400", 1'b0, 1'b1, 32'h400, 32'h0BADF00D, 2'b10, 1'b0, 32'h0000_0000, 1'b0);
    req("lw_000", 1'b1, 1'b0, 32'h000, 32'h0,        2'b10, 1'b0, 32'h0BAD_F00D, 1'b0);
    req("rw_04",  1'b1, 1'b1, 32'h04,  32'h55AA55AA, 2'b10, 1'b0, 32'h0000_0000, 1'b0);
    req("lw_04",  1'b1, 1'b0, 32'h04,  32'h0,        2'b11, 1'b0, 32'h55AA_55AA, 1'b0);
    req("lhu_06", 1'b1, 1'b0, 32'h06,  32'h0,        2'b01, 1'b1, 32'h0000_55AA, 1'b0);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
